// File: rtl/spi_flash_reader.sv
// rtl/spi_flash_reader.sv - SPI flash READ command sequencer feeding a byte-level PHY
module spi_flash_reader #(
    parameter logic [7:0] CMD_READ  = 8'h03,
    parameter logic [7:0] DUMMY_OUT = 8'hFF,
    parameter int         LEN_W     = 16,
    parameter int         CS_GAP    = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_req,
    input  logic [23:0]      i_addr,
    input  logic [LEN_W-1:0] i_len,
    output logic             o_busy,
    output logic [7:0]       o_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic             o_done,
    output logic             o_phy_cs,
    output logic             o_phy_wr,
    output logic [7:0]       o_phy_data,
    input  logic             i_phy_busy,
    input  logic             i_phy_rdy,
    input  logic [7:0]       i_phy_data
);

    localparam int GAP_W = (CS_GAP < 2) ? 1 : $clog2(CS_GAP);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_DATA,
        S_END,
        S_GAP
    } state_t;

    state_t           r_state;
    logic [23:0]      r_addr;
    logic [LEN_W-1:0] r_rem;
    logic [1:0]       r_acnt;
    logic [GAP_W-1:0] r_gap;
    logic             r_pend;
    logic             r_busy;
    logic             r_valid;
    logic             r_done;
    logic             r_cs;
    logic             r_phy_wr;
    logic [7:0]       r_data;
    logic [7:0]       r_phy_data;

    logic       w_issue;
    logic       w_xfer;
    logic       w_accept;
    logic [7:0] w_addr_byte;

    // r_pend marks the single exchange in flight; stray PHY ready pulses are dropped
    assign w_issue  = !r_pend && !i_phy_busy;
    assign w_xfer   = r_pend && i_phy_rdy;
    assign w_accept = r_valid && i_ready;

    always_comb begin
        w_addr_byte = r_addr[7:0];
        case (r_acnt)
            2'd0:    w_addr_byte = r_addr[23:16];
            2'd1:    w_addr_byte = r_addr[15:8];
            default: w_addr_byte = r_addr[7:0];
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= S_IDLE;
            r_addr     <= '0;
            r_rem      <= '0;
            r_acnt     <= '0;
            r_gap      <= '0;
            r_pend     <= 1'b0;
            r_busy     <= 1'b0;
            r_valid    <= 1'b0;
            r_done     <= 1'b0;
            r_cs       <= 1'b0;
            r_phy_wr   <= 1'b0;
            r_data     <= 8'h00;
            r_phy_data <= 8'h00;
        end else begin
            r_phy_wr <= 1'b0;
            r_done   <= 1'b0;
            if (w_accept) begin
                r_valid <= 1'b0;
            end
            case (r_state)
                S_IDLE: begin
                    if (i_req) begin
                        r_addr  <= i_addr;
                        r_rem   <= i_len;
                        r_busy  <= 1'b1;
                        r_cs    <= 1'b1;
                        r_state <= S_CMD;
                    end
                end
                S_CMD: begin
                    if (w_xfer) begin
                        r_pend  <= 1'b0;
                        r_acnt  <= 2'd0;
                        r_state <= S_ADDR;
                    end else if (w_issue) begin
                        r_phy_wr   <= 1'b1;
                        r_phy_data <= CMD_READ;
                        r_pend     <= 1'b1;
                    end
                end
                S_ADDR: begin
                    if (w_xfer) begin
                        r_pend <= 1'b0;
                        if (r_acnt == 2'd2) begin
                            r_state <= (r_rem == '0) ? S_END : S_DATA;
                        end else begin
                            r_acnt <= r_acnt + 2'd1;
                        end
                    end else if (w_issue) begin
                        r_phy_wr   <= 1'b1;
                        r_phy_data <= w_addr_byte;
                        r_pend     <= 1'b1;
                    end
                end
                S_DATA: begin
                    // a full output register stalls the wire; CS stays asserted
                    if (w_xfer) begin
                        r_pend  <= 1'b0;
                        r_data  <= i_phy_data;
                        r_valid <= 1'b1;
                        r_rem   <= r_rem - 1'b1;
                    end else if (r_rem == '0 && !r_valid && !r_pend) begin
                        r_state <= S_END;
                    end else if (r_rem != '0 && !r_valid && w_issue) begin
                        r_phy_wr   <= 1'b1;
                        r_phy_data <= DUMMY_OUT;
                        r_pend     <= 1'b1;
                    end
                end
                S_END: begin
                    r_cs    <= 1'b0;
                    r_done  <= 1'b1;
                    r_gap   <= '0;
                    r_state <= S_GAP;
                end
                S_GAP: begin
                    if (r_gap == GAP_W'(CS_GAP - 1)) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_gap <= r_gap + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_busy     = r_busy;
    assign o_data     = r_data;
    assign o_valid    = r_valid;
    assign o_done     = r_done;
    assign o_phy_cs   = r_cs;
    assign o_phy_wr   = r_phy_wr;
    assign o_phy_data = r_phy_data;

endmodule

// File: tb/tb_spi_flash_reader.sv
// tb/tb_spi_flash_reader.sv - directed bench for spi_flash_reader with a byte-level PHY model
module tb_spi_flash_reader;

    typedef logic [7:0] bq_t[$];

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_req = 1'b0;
    logic [23:0] i_addr = '0;
    logic [15:0] i_len = '0;
    logic        i_ready = 1'b0;
    logic        i_phy_busy = 1'b0;
    logic        i_phy_rdy = 1'b0;
    logic [7:0]  i_phy_data = 8'h00;
    logic        o_busy, o_valid, o_done, o_phy_cs, o_phy_wr;
    logic [7:0]  o_data, o_phy_data;

    int n_checks = 0;
    int n_fail = 0;

    bq_t tx_q, rx_q, resp_q, exp_q;
    int  phy_lat = 2;
    bit  phy_rand = 1'b0;
    int  viol_multi = 0, viol_stable = 0, viol_cs = 0;
    int  done_cnt = 0, valid_seen = 0;

    bit       m_busy = 1'b0;
    int       m_cnt = 0, m_idx = 0, m_wrs = 0;
    logic [7:0] m_cur = 8'h00, m_resp = 8'h00;

    spi_flash_reader dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_req      (i_req),
        .i_addr     (i_addr),
        .i_len      (i_len),
        .o_busy     (o_busy),
        .o_data     (o_data),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_done     (o_done),
        .o_phy_cs   (o_phy_cs),
        .o_phy_wr   (o_phy_wr),
        .o_phy_data (o_phy_data),
        .i_phy_busy (i_phy_busy),
        .i_phy_rdy  (i_phy_rdy),
        .i_phy_data (i_phy_data)
    );

    always #5 i_clk = ~i_clk;

    // PHY model: one exchange at a time, replies 5A to command/address bytes
    initial begin
        forever begin
            @(posedge i_clk);
            #1;
            if (!i_rst_n) begin
                m_busy = 1'b0; m_cnt = 0; m_idx = 0; m_wrs = 0;
                i_phy_rdy = 1'b0; i_phy_busy = 1'b0;
                continue;
            end
            i_phy_rdy = 1'b0;
            if (!o_phy_cs) m_idx = 0;
            if (m_busy) begin
                if (o_phy_data !== m_cur) viol_stable++;
                m_cnt--;
                if (m_cnt <= 0) begin
                    m_busy = 1'b0;
                    i_phy_rdy = 1'b1;
                    i_phy_data = m_resp;
                    m_wrs = 0;
                end
            end
            if (o_phy_wr) begin
                if (m_busy || m_wrs != 0) viol_multi++;
                if (!o_phy_cs) viol_cs++;
                m_wrs++;
                m_busy = 1'b1;
                m_cur = o_phy_data;
                tx_q.push_back(o_phy_data);
                m_cnt = phy_rand ? int'($urandom_range(1, 16)) : phy_lat;
                m_resp = 8'h5A;
                if (m_idx >= 4 && resp_q.size() > 0) m_resp = resp_q.pop_front();
                m_idx++;
            end
            i_phy_busy = m_busy;
        end
    end

    always @(negedge i_clk) begin
        if (i_rst_n) begin
            if (o_valid && i_ready) rx_q.push_back(o_data);
            if (o_done) done_cnt++;
            if (o_valid) valid_seen++;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_seq(input string tag, input bq_t got, input bq_t exp);
        check({tag, "_len"}, got.size(), exp.size());
        for (int i = 0; i < exp.size() && i < got.size(); i++)
            check($sformatf("%s_%0d", tag, i), {24'h0, got[i]}, {24'h0, exp[i]});
    endtask

    task automatic clear_logs();
        tx_q.delete(); rx_q.delete(); resp_q.delete(); exp_q.delete();
        done_cnt = 0; valid_seen = 0;
        viol_multi = 0; viol_stable = 0; viol_cs = 0;
    endtask

    task automatic start(input logic [23:0] addr, input logic [15:0] len);
        @(posedge i_clk); #1;
        i_req = 1'b1; i_addr = addr; i_len = len;
        @(posedge i_clk); #1;
        i_req = 1'b0;
    endtask

    task automatic wait_idle(output int gap, output int tmo);
        gap = 0; tmo = 1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge i_clk);
            if (!o_phy_cs && o_busy) gap++;
            if (!o_busy) begin tmo = 0; break; end
        end
    endtask

    int gap, tmo, stall_wr, stall_cslow, cyc;

    initial begin
        // reset state
        #12;
        check("rst_busy", o_busy, 0);
        check("rst_valid", o_valid, 0);
        check("rst_done", o_done, 0);
        check("rst_cs", o_phy_cs, 0);
        check("rst_wr", o_phy_wr, 0);
        check("rst_data", o_data, 0);
        check("rst_phy_data", o_phy_data, 0);
        @(negedge i_clk); i_rst_n = 1'b1;

        // basic read, len 2, plus request-to-strobe latency
        clear_logs();
        i_ready = 1'b1;
        resp_q = {8'hAA, 8'h55};
        start(24'h012345, 16'd2);
        check("t1_busy_after_req", o_busy, 1);
        check("t1_cs_after_req", o_phy_cs, 1);
        check("t1_wr_cycle1", o_phy_wr, 0);
        @(posedge i_clk); #1;
        check("t1_wr_cycle2", o_phy_wr, 1);
        check("t1_opcode", o_phy_data, 8'h03);
        wait_idle(gap, tmo);
        check("t1_timeout", tmo, 0);
        exp_q = {8'h03, 8'h01, 8'h23, 8'h45, 8'hFF, 8'hFF};
        check_seq("t1_tx", tx_q, exp_q);
        exp_q = {8'hAA, 8'h55};
        check_seq("t1_rx", rx_q, exp_q);
        check("t1_done_cnt", done_cnt, 1);
        check("t1_gap_ge4", gap >= 4, 1);
        check("t1_cs_viol", viol_cs, 0);

        // zero-length read at top of address space
        clear_logs();
        start(24'hFFFFFF, 16'd0);
        wait_idle(gap, tmo);
        check("t2_timeout", tmo, 0);
        exp_q = {8'h03, 8'hFF, 8'hFF, 8'hFF};
        check_seq("t2_tx", tx_q, exp_q);
        check("t2_valid_seen", valid_seen, 0);
        check("t2_done_cnt", done_cnt, 1);

        // backpressure: hold ready low for 10 cycles after first byte
        clear_logs();
        i_ready = 1'b0;
        resp_q = {8'h11, 8'h22, 8'h33};
        start(24'h000100, 16'd3);
        cyc = 0;
        while (!o_valid && cyc < 500) begin @(negedge i_clk); cyc++; end
        check("t3_first_valid", o_valid, 1);
        stall_wr = 0; stall_cslow = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge i_clk);
            if (o_phy_wr) stall_wr++;
            if (!o_phy_cs) stall_cslow++;
        end
        check("t3_stall_wr", stall_wr, 0);
        check("t3_stall_cs", stall_cslow, 0);
        check("t3_stall_data", o_data, 8'h11);
        check("t3_stall_tx", tx_q.size(), 5);
        i_ready = 1'b1;
        wait_idle(gap, tmo);
        check("t3_timeout", tmo, 0);
        exp_q = {8'h11, 8'h22, 8'h33};
        check_seq("t3_rx", rx_q, exp_q);
        check("t3_tx_len", tx_q.size(), 7);

        // repeated requests while busy are ignored
        clear_logs();
        resp_q = {8'hC3};
        start(24'h00ABCD, 16'd1);
        for (int i = 0; i < 5; i++) begin
            i_req = 1'b1; i_addr = 24'h777777; i_len = 16'd5;
            @(posedge i_clk); #1;
            i_req = 1'b0;
            @(posedge i_clk); #1;
        end
        wait_idle(gap, tmo);
        check("t4_timeout", tmo, 0);
        exp_q = {8'h03, 8'h00, 8'hAB, 8'hCD, 8'hFF};
        check_seq("t4_tx", tx_q, exp_q);
        exp_q = {8'hC3};
        check_seq("t4_rx", rx_q, exp_q);
        check("t4_done_cnt", done_cnt, 1);
        clear_logs();
        resp_q = {8'h9E};
        start(24'h102030, 16'd1);
        wait_idle(gap, tmo);
        check("t4b_timeout", tmo, 0);
        exp_q = {8'h03, 8'h10, 8'h20, 8'h30, 8'hFF};
        check_seq("t4b_tx", tx_q, exp_q);
        exp_q = {8'h9E};
        check_seq("t4b_rx", rx_q, exp_q);

        // reset during the second data byte
        clear_logs();
        resp_q = {8'h01, 8'h02, 8'h03};
        start(24'h00F00D, 16'd3);
        cyc = 0;
        while (tx_q.size() < 6 && cyc < 500) begin @(negedge i_clk); cyc++; end
        check("t5_reached_byte2", tx_q.size(), 6);
        #1 i_rst_n = 1'b0;
        #1;
        check("t5_rst_cs", o_phy_cs, 0);
        check("t5_rst_valid", o_valid, 0);
        check("t5_rst_busy", o_busy, 0);
        repeat (3) @(negedge i_clk);
        i_rst_n = 1'b1;
        clear_logs();
        resp_q = {8'hDE, 8'hAD};
        start(24'h0A0B0C, 16'd2);
        wait_idle(gap, tmo);
        check("t5_timeout", tmo, 0);
        exp_q = {8'h03, 8'h0A, 8'h0B, 8'h0C, 8'hFF, 8'hFF};
        check_seq("t5_tx", tx_q, exp_q);
        exp_q = {8'hDE, 8'hAD};
        check_seq("t5_rx", rx_q, exp_q);
        check("t5_done_cnt", done_cnt, 1);

        // variable PHY exchange time
        clear_logs();
        phy_rand = 1'b1;
        for (int i = 0; i < 8; i++) resp_q.push_back(8'($urandom));
        exp_q = resp_q;
        start(24'h345678, 16'd8);
        wait_idle(gap, tmo);
        check("t6_timeout", tmo, 0);
        check_seq("t6_rx", rx_q, exp_q);
        check("t6_tx_len", tx_q.size(), 12);
        check("t6_multi_wr", viol_multi, 0);
        check("t6_data_stable", viol_stable, 0);
        check("t6_cs_viol", viol_cs, 0);
        check("t6_gap_ge4", gap >= 4, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_flash_reader.md
Name: spi_flash_reader

Overview:
- Command sequencer directly upstream of the byte-level SPI PHY.
- Accepts a read request (24-bit flash address, byte count) and drives the PHY through chip-select, the READ opcode, three address bytes and N dummy-out/data-in byte exchanges.
- Presents the received bytes on a valid/ready stream to the consumer, e.g. the boot loader that copies flash into memory.
- Provides backpressure: no new byte exchange starts while the output register holds unaccepted data.

Parameters:
- CMD_READ, 8'h03, opcode sent as the first byte of every transaction.
- DUMMY_OUT, 8'hFF, byte shifted out while reading data.
- LEN_W, 16, width of the byte-count input.
- CS_GAP, 4, minimum clock cycles o_phy_cs stays low between transactions (≥1).

Ports:
- i_clk  in  1  system clock (single clock domain).
- i_rst_n  in  1  asynchronous, active-low reset.
- i_req  in  1  start request; sampled only when o_busy=0.
- i_addr  in  24  flash start address, MSB byte first on the wire.
- i_len  in  LEN_W  number of data bytes to read; 0 = command+address only.
- o_busy  out  1  high from accepted request until the end of the CS_GAP.
- o_data  out  8  received data byte.
- o_valid  out  1  o_data holds an unaccepted byte.
- i_ready  in  1  consumer accepts o_data when o_valid&&i_ready.
- o_done  out  1  one-cycle pulse when CS deasserts at the end of a transaction.
- o_phy_cs  out  1  chip-select request, active-high; the PHY drives the pin active-low.
- o_phy_wr  out  1  one-cycle strobe: start one byte exchange with o_phy_data.
- o_phy_data  out  8  byte to transmit; stable while i_phy_busy.
- i_phy_busy  in  1  PHY exchange in progress.
- i_phy_rdy  in  1  one-cycle pulse: exchange complete, i_phy_data valid.
- i_phy_data  in  8  byte received in the last exchange.

Behaviour:
- Reset state (async, i_rst_n=0):
  - State IDLE.
  - o_busy, o_valid, o_done, o_phy_cs and o_phy_wr are all 0.
  - o_data and o_phy_data are 8'h00.
  - Counters are 0.
- Reset mid-transaction: o_phy_cs drops immediately (asynchronously) and any partial data is discarded.
- IDLE:
  - i_req=1 latches i_addr/i_len, sets o_busy=1 and o_phy_cs=1 in the next cycle, then moves to CMD.
  - i_req while o_busy=1 is ignored.
- CMD:
  - Issue o_phy_wr with CMD_READ, then wait for i_phy_rdy.
  - o_phy_wr is only issued when i_phy_busy=0, and at most one strobe is outstanding.
- ADDR: three exchanges in the order addr[23:16], addr[15:8], addr[7:0], tracked by a 2-bit counter. Bytes received in CMD/ADDR are discarded.
- DATA:
  - While the remaining count is ≠0 and o_valid=0, issue o_phy_wr with DUMMY_OUT.
  - On i_phy_rdy: o_data<=i_phy_data, o_valid<=1, remaining count decrements.
  - If o_valid=1 and i_ready=0, hold the state; no strobe is issued and CS stays high.
  - A handshake in the same cycle as i_phy_rdy cannot occur, because only one byte is in flight.
  - The next strobe may issue in the cycle after acceptance (o_valid&&i_ready).
- END:
  - Entered when remaining=0 and o_valid=0 (last byte accepted), or directly after ADDR when len=0.
  - o_phy_cs<=0 and o_done pulses for 1 cycle.
- GAP:
  - Hold o_phy_cs=0 for CS_GAP cycles, then o_busy<=0 and return to IDLE.
  - An i_req in the same cycle o_busy falls is not accepted; it is accepted in the next cycle.
- Latency and width rules:
  - Minimum latency from i_req to first o_phy_wr is 2 cycles.
  - The address register is exactly 24 bits; no wrap handling is needed, because flash wraps internally.
  - i_len=max (2^LEN_W−1) must work; the counter is LEN_W bits wide with no overflow.
- An unexpected i_phy_rdy outside an outstanding exchange is ignored.

Test Plan:
- Reset released, i_req with addr=24'h012345, len=2:
  - PHY sees bytes 03,01,23,45,FF,FF with CS high throughout.
  - The PHY model returns AA then 55; o_data streams AA, 55.
  - o_done pulses once, then CS is low for ≥4 cycles before o_busy=0.
- len=0 at addr=24'hFFFFFF: exactly 4 exchanges (03,FF,FF,FF), o_valid never asserts, o_done pulses.
- Backpressure, len=3 with i_ready held low for 10 cycles after the first byte:
  - No o_phy_wr during the stall; CS stays high.
  - All three bytes are delivered in order after i_ready rises.
- i_req pulsed repeatedly during a transaction: ignored, and a single transaction is observed. A second i_req after o_busy=0 starts a new transaction with the new address.
- i_rst_n asserted during the second data byte: o_phy_cs, o_valid and o_busy are 0 immediately. The next request completes correctly.
- PHY model with variable exchange time (1–16 cycles): never more than one o_phy_wr between i_phy_rdy pulses, and o_phy_data stable while i_phy_busy.
